// File: rtl/gate_response_checker.sv
// rtl/gate_response_checker.sv - receive-side checker comparing a 2-input gate response against a truth table
module gate_response_checker #(
   parameter logic [3:0] FUNC   = 4'b1110,
   parameter int         SETTLE = 2,
   parameter int         NVEC   = 16,
   parameter int         ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             x,
   input  logic             y,
   input  logic             z,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [3:0]       cov,
   output logic [2:0]       first_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_CHECK,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);
   localparam logic [7:0] NVEC_C   = 8'(NVEC);

   state_t           state;
   logic             x_q, y_q, z_q;
   logic [3:0]       stab;
   logic [7:0]       nchk;

   logic [1:0]       xy_q;
   logic             xy_chg;
   logic [3:0]       stab_nxt;
   logic             mism;
   logic [ERR_W-1:0] err_nxt;
   logic [3:0]       cov_nxt;
   logic [7:0]       nchk_nxt;

   // xy_chg looks one register ahead: it is true when x_q/y_q are about to
   // take a value different from the one they hold now.
   always_comb begin
      xy_q     = {x_q, y_q};
      xy_chg   = ({x, y} != xy_q);
      stab_nxt = xy_chg ? 4'd0 : ((stab == SETTLE_C) ? stab : stab + 4'd1);
      mism     = (z_q != FUNC[xy_q]);
      err_nxt  = (mism && !(&err_count)) ? err_count + ERR_W'(1) : err_count;
      cov_nxt  = cov | (4'b0001 << xy_q);
      nchk_nxt = nchk + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         x_q       <= 1'b0;
         y_q       <= 1'b0;
         z_q       <= 1'b0;
         stab      <= 4'd0;
         nchk      <= 8'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         cov       <= 4'd0;
         first_err <= 3'd0;
      end else begin
         x_q  <= x;
         y_q  <= y;
         z_q  <= z;
         stab <= stab_nxt;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  err_count <= '0;
                  cov       <= 4'd0;
                  first_err <= 3'd0;
                  nchk      <= 8'd0;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  stab      <= 4'd0;
                  busy      <= 1'b1;
                  state     <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (stab_nxt == SETTLE_C) state <= S_CHECK;
            end
            S_CHECK: begin
               err_count <= err_nxt;
               if (mism && (err_count == '0)) first_err <= {xy_q, z_q};
               cov  <= cov_nxt;
               nchk <= nchk_nxt;
               if (nchk_nxt == NVEC_C) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_nxt == '0) && (cov_nxt == 4'hF);
                  state <= S_DONE;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (xy_chg) state <= S_SETTLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_response_checker.sv
// tb/tb_gate_response_checker.sv - directed bench for gate_response_checker
module tb_gate_response_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       start_sat = 1'b0;
   logic       x = 1'b0;
   logic       y = 1'b0;
   logic       z;
   logic       z_stuck = 1'b0;

   logic       busy, done, pass;
   logic [7:0] err_count;
   logic [3:0] cov;
   logic [2:0] first_err;

   logic       busy_s, done_s, pass_s;
   logic [1:0] err_count_s;
   logic [3:0] cov_s;
   logic [2:0] first_err_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // modelled gate under test: an OR gate, optionally with its output stuck at 0
   always_comb z = z_stuck ? 1'b0 : (x | y);

   gate_response_checker #(.FUNC(4'b1110), .SETTLE(2), .NVEC(4), .ERR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .z(z),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .cov(cov), .first_err(first_err)
   );

   gate_response_checker #(.FUNC(4'b1110), .SETTLE(2), .NVEC(6), .ERR_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start_sat), .x(x), .y(y), .z(z),
      .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_count_s),
      .cov(cov_s), .first_err(first_err_s)
   );

   task automatic hold(input logic [1:0] v, input int n);
      {x, y} = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, pass, err_count, cov, first_err} !== 18'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h exp 0", {busy, done, pass, err_count, cov, first_err});
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_partial_cov();
      z_stuck = 1'b0;
      {x, y} = 2'b00;
      pulse_start();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b exp 1", busy); end
      hold(2'b00, 20);
      hold(2'b10, 20);
      hold(2'b11, 20);
      hold(2'b10, 20);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL t1_done: got done=%b busy=%b exp 1/0", done, busy); end
      checks++;
      if (err_count !== 8'd0) begin errors++; $display("FAIL t1_err: got %0d exp 0", err_count); end
      checks++;
      if (cov !== 4'b1101) begin errors++; $display("FAIL t1_cov: got %b exp 1101", cov); end
      checks++;
      if (pass !== 1'b0) begin errors++; $display("FAIL t1_pass: got %b exp 0", pass); end
   endtask

   task automatic test_full_pass();
      z_stuck = 1'b0;
      {x, y} = 2'b00;
      pulse_start();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL t2_done_cleared: got %b exp 0", done); end
      hold(2'b00, 20);
      hold(2'b01, 20);
      hold(2'b10, 20);
      // last vector set just after edge P: CHECK at P+3, done visible after P+4
      hold(2'b11, 3);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL t2_done_early: got %b exp 0", done); end
      hold(2'b11, 1);
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL t2_done_latency: got %b exp 1", done); end
      hold(2'b11, 10);
      checks++;
      if (err_count !== 8'd0 || cov !== 4'hF) begin errors++; $display("FAIL t2_err_cov: got %0d/%h exp 0/f", err_count, cov); end
      checks++;
      if (pass !== 1'b1 || first_err !== 3'd0) begin errors++; $display("FAIL t2_pass: got pass=%b fe=%b exp 1/000", pass, first_err); end
   endtask

   task automatic test_stuck_low();
      z_stuck = 1'b1;
      {x, y} = 2'b00;
      pulse_start();
      hold(2'b00, 20);
      hold(2'b01, 20);
      hold(2'b10, 20);
      hold(2'b11, 20);
      checks++;
      if (done !== 1'b1 || err_count !== 8'd3) begin errors++; $display("FAIL t3_err: got done=%b err=%0d exp 1/3", done, err_count); end
      checks++;
      if (first_err !== 3'b010) begin errors++; $display("FAIL t3_first_err: got %b exp 010", first_err); end
      checks++;
      if (pass !== 1'b0 || cov !== 4'hF) begin errors++; $display("FAIL t3_pass: got pass=%b cov=%h exp 0/f", pass, cov); end
      z_stuck = 1'b0;
   endtask

   task automatic test_glitch();
      z_stuck = 1'b0;
      {x, y} = 2'b01;
      pulse_start();
      hold(2'b11, 1);
      hold(2'b01, 20);
      hold(2'b00, 1);
      hold(2'b01, 20);
      hold(2'b00, 20);
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || cov !== 4'b0011) begin
         errors++;
         $display("FAIL t4_mid: got done=%b busy=%b cov=%b exp 0/1/0011", done, busy, cov);
      end
      hold(2'b11, 1);
      hold(2'b00, 20);
      checks++;
      if (done !== 1'b1 || cov !== 4'b0011 || err_count !== 8'd0) begin
         errors++;
         $display("FAIL t4_end: got done=%b cov=%b err=%0d exp 1/0011/0", done, cov, err_count);
      end
   endtask

   task automatic test_saturation();
      z_stuck = 1'b1;
      {x, y} = 2'b00;
      start_sat = 1'b1;
      @(posedge clk);
      #1 start_sat = 1'b0;
      hold(2'b00, 20);
      hold(2'b01, 20);
      hold(2'b10, 20);
      hold(2'b11, 20);
      checks++;
      if (err_count_s !== 2'd3 || done_s !== 1'b0) begin errors++; $display("FAIL t5_mid: got err=%0d done=%b exp 3/0", err_count_s, done_s); end
      hold(2'b01, 20);
      hold(2'b10, 20);
      checks++;
      if (done_s !== 1'b1 || err_count_s !== 2'd3) begin errors++; $display("FAIL t5_sat: got done=%b err=%0d exp 1/3", done_s, err_count_s); end
      checks++;
      if (first_err_s !== 3'b010 || pass_s !== 1'b0) begin errors++; $display("FAIL t5_first_err: got fe=%b pass=%b exp 010/0", first_err_s, pass_s); end
      z_stuck = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      z_stuck = 1'b1;
      {x, y} = 2'b00;
      pulse_start();
      hold(2'b00, 20);
      hold(2'b01, 20);
      checks++;
      if (busy !== 1'b1 || err_count !== 8'd1) begin errors++; $display("FAIL t6_before: got busy=%b err=%0d exp 1/1", busy, err_count); end
      rst_n = 1'b0;
      #2;
      checks++;
      if ({busy, done, pass, err_count, cov, first_err} !== 18'd0 ||
          {busy_s, done_s, pass_s, err_count_s, cov_s, first_err_s} !== 12'd0) begin
         errors++;
         $display("FAIL t6_in_reset: got %h/%h exp 0/0",
                  {busy, done, pass, err_count, cov, first_err},
                  {busy_s, done_s, pass_s, err_count_s, cov_s, first_err_s});
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      z_stuck = 1'b0;
      hold(2'b00, 2);
      pulse_start();
      hold(2'b00, 20);
      hold(2'b01, 20);
      hold(2'b10, 20);
      hold(2'b11, 20);
      checks++;
      if (done !== 1'b1 || err_count !== 8'd0 || cov !== 4'hF || pass !== 1'b1) begin
         errors++;
         $display("FAIL t6_rerun: got done=%b err=%0d cov=%h pass=%b exp 1/0/f/1", done, err_count, cov, pass);
      end
   endtask

   initial begin
      test_reset();
      test_partial_cov();
      test_full_pass();
      test_stuck_low();
      test_glitch();
      test_saturation();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
